// File: rtl/universal_shift_reg.sv
// Universal shift register: single-cycle hold/load/clear commands and
// multi-cycle shift/rotate commands that step one bit per clock.
module universal_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter int               AMT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       mode_q,  mode_d;
    logic [WIDTH-1:0] reg_q,   reg_d;
    logic             sout_q,  sout_d;
    logic             done_q,  done_d;

    // One single-bit step of a shift/rotate mode; returns {bit_out, new_value}.
    function automatic logic [WIDTH:0] step_fn(input logic [2:0]       m,
                                               input logic [WIDTH-1:0] v,
                                               input logic             s);
        logic [WIDTH:0] r;
        r = {1'b0, v};
        case (m)
            M_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0], s};
            M_SHR:   r = {v[0], s, v[WIDTH-1:1]};
            M_ROTL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            M_ROTR:  r = {v[0], v[0], v[WIDTH-1:1]};
            M_ASR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    logic [WIDTH:0] step_res;
    assign step_res = step_fn(mode_q, reg_q, sin);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        reg_d   = reg_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mode)
                        M_HOLD:  done_d = 1'b1;
                        M_LOAD:  begin reg_d = d;  done_d = 1'b1; end
                        M_CLEAR: begin reg_d = '0; done_d = 1'b1; end
                        default: begin
                            // Zero-length shifts complete immediately without entering SHIFT.
                            if (amount == '0) begin
                                done_d = 1'b1;
                            end else begin
                                mode_d  = mode;
                                cnt_d   = amount;
                                state_d = S_SHIFT;
                            end
                        end
                    endcase
                end
            end
            default: begin
                reg_d  = step_res[WIDTH-1:0];
                sout_d = step_res[WIDTH];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            reg_q   <= RST_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            reg_q   <= reg_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q    = reg_q;
    assign qbar = ~reg_q;
    assign sout = sout_q;
    assign busy = (state_q == S_SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, AMT_W=4, RST_VAL=0).
module tb_universal_shift_reg;

    typedef struct {
        logic       start;
        logic [2:0] mode;
        logic [3:0] amt;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic       eb;
        logic       ed;
        logic       es;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] d;
    logic       sin;
    logic [7:0] q, qbar;
    logic       sout, busy, done;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tv[$];

    universal_shift_reg #(.WIDTH(8), .AMT_W(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
        .d(d), .sin(sin), .q(q), .qbar(qbar), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic [2:0] m, input logic [3:0] a,
                                input logic [7:0] dd, input logic s, input logic [7:0] eq,
                                input logic eb, input logic ed, input logic es);
        vec_t v;
        v.start = st; v.mode = m; v.amt = a; v.d = dd; v.sin = s;
        v.eq = eq; v.eb = eb; v.ed = ed; v.es = es;
        return v;
    endfunction

    task automatic check_state(input string name, input logic [7:0] eq, input logic eb,
                               input logic ed, input logic es);
        n_vec++;
        if (q !== eq || qbar !== ~eq || busy !== eb || done !== ed || sout !== es) begin
            n_bad++;
            $display("FAIL %s: got q=%h qbar=%h busy=%b done=%b sout=%b, want q=%h qbar=%h busy=%b done=%b sout=%b",
                     name, q, qbar, busy, done, sout, eq, ~eq, eb, ed, es);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string name);
        start = v.start; mode = v.mode; amount = v.amt; d = v.d; sin = v.sin;
        tick();
        check_state(name, v.eq, v.eb, v.ed, v.es);
    endtask

    // Launch a long command and count cycles with busy high until it finishes.
    task automatic long_cmd(input logic [2:0] m, input logic [3:0] a, input logic s,
                            output int busy_cycles);
        start = 1'b1; mode = m; amount = a; sin = s;
        tick();
        start = 1'b0; mode = 3'b000;
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            tick();
        end
    endtask

    initial begin
        int bc;
        rst = 1'b1; start = 1'b0; mode = 3'b000; amount = 4'd0; d = 8'h00; sin = 1'b0;
        #3;
        check_state("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        #9 rst = 1'b0;

        //        st  mode    amt  d      sin   q      busy done sout
        tv.push_back(mk(1, 3'b001, 0, 8'hA5, 0, 8'hA5, 0, 1, 0));
        tv.push_back(mk(1, 3'b010, 3, 8'h00, 0, 8'hA5, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'h4A, 1, 0, 1));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'h94, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'h28, 0, 1, 1));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'h28, 0, 0, 1));
        tv.push_back(mk(1, 3'b001, 0, 8'h80, 0, 8'h80, 0, 1, 1));
        tv.push_back(mk(1, 3'b110, 2, 8'h00, 0, 8'h80, 1, 0, 1));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'hC0, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'hE0, 0, 1, 0));
        tv.push_back(mk(1, 3'b001, 0, 8'h81, 0, 8'h81, 0, 1, 0));
        tv.push_back(mk(1, 3'b101, 1, 8'h00, 0, 8'h81, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'hC0, 0, 1, 1));
        tv.push_back(mk(1, 3'b111, 0, 8'h00, 0, 8'h00, 0, 1, 1));
        tv.push_back(mk(1, 3'b011, 4, 8'h00, 1, 8'h00, 1, 0, 1));
        tv.push_back(mk(1, 3'b001, 0, 8'hFF, 1, 8'h80, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 1, 8'hC0, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 1, 8'hE0, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 1, 8'hF0, 0, 1, 0));
        tv.push_back(mk(1, 3'b010, 0, 8'h00, 1, 8'hF0, 0, 1, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'hF0, 0, 0, 0));
        tv.push_back(mk(1, 3'b100, 1, 8'h00, 0, 8'hF0, 1, 0, 0));
        tv.push_back(mk(0, 3'b000, 0, 8'h00, 0, 8'hE1, 0, 1, 1));
        tv.push_back(mk(1, 3'b000, 0, 8'h55, 0, 8'hE1, 0, 1, 1));
        tv.push_back(mk(0, 3'b111, 0, 8'h55, 0, 8'hE1, 0, 0, 1));

        foreach (tv[i]) apply(tv[i], $sformatf("vec%0d", i));

        // Amounts larger than WIDTH: shifts saturate, rotations wrap.
        apply(mk(1, 3'b001, 0, 8'h5A, 0, 8'h5A, 0, 1, 1), "load_5A");
        long_cmd(3'b010, 4'd10, 1'b1, bc);
        check_val("shl10_busy_cycles", bc, 10);
        check_state("shl10_final", 8'hFF, 1'b0, 1'b1, 1'b1);
        apply(mk(1, 3'b001, 0, 8'h5A, 0, 8'h5A, 0, 1, 1), "reload_5A");
        long_cmd(3'b100, 4'd9, 1'b0, bc);
        check_val("rotl9_busy_cycles", bc, 9);
        check_state("rotl9_final", 8'hB4, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1 check_state("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        check_state("after_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset aborts a shift after 2 of 5 steps; no done is ever produced.
        apply(mk(1, 3'b001, 0, 8'h0F, 0, 8'h0F, 0, 1, 0), "load_0F");
        apply(mk(1, 3'b010, 5, 8'h00, 1, 8'h0F, 1, 0, 0), "shl5_start");
        apply(mk(0, 3'b000, 0, 8'h00, 1, 8'h1F, 1, 0, 0), "shl5_step1");
        apply(mk(0, 3'b000, 0, 8'h00, 1, 8'h3F, 1, 0, 0), "shl5_step2");
        #2 rst = 1'b1;
        #1 check_state("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("abort_rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) apply(mk(0, 3'b000, 0, 8'h00, 1, 8'h00, 0, 0, 0), $sformatf("abort_quiet%0d", i));
        apply(mk(1, 3'b001, 0, 8'h3C, 0, 8'h3C, 0, 1, 0), "load_3C");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range >= 2.
REQ-002 SHALL have parameter AMT_W, default 4, width of the shift-amount port.
REQ-003 SHALL have parameter RST_VAL, default 0 (WIDTH bits), value loaded into q on reset.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  command strobe, sampled on posedge clk when idle.
REQ-007 mode  in  3  command: 000 hold, 001 load, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 ASR, 111 clear.
REQ-008 amount  in  AMT_W  number of single-bit shift steps for modes 010-110.
REQ-009 d  in  WIDTH  parallel load data.
REQ-010 sin  in  1  serial input: enters LSB on SHL, MSB on SHR; sampled every shift step.
REQ-011 q  out  WIDTH  register contents.
REQ-012 qbar  out  WIDTH  bitwise complement of q, always equal to ~q.
REQ-013 sout  out  1  registered copy of the last bit shifted or rotated out.
REQ-014 busy  out  1  high while a multi-cycle shift is in progress.
REQ-015 done  out  1  one-cycle pulse marking command completion.

Function
REQ-016 SHALL implement FSM with states IDLE and SHIFT, plus a step counter of AMT_W bits.
REQ-017 IDLE, start=0: q, sout hold; done=0.
REQ-018 IDLE, start=1, mode 000/001/111 at edge t: q <= q / d / 0 at edge t; done=1 for the cycle after edge t; busy stays 0; sout unchanged.
REQ-019 IDLE, start=1, mode 010-110, amount=N>0 at edge t: latch mode, load counter=N, go to SHIFT, busy=1; q unchanged at edge t.
REQ-020 IDLE, start=1, shift mode, amount=0: no state change, q and sout unchanged, done=1 for the cycle after edge t.
REQ-021 SHIFT: edges t+1 .. t+N each perform one step of the latched mode and decrement the counter; mode, amount and start inputs ignored.
REQ-022 Step rules: SHL q<={q[W-2:0],sin}, sout<=q[W-1]; SHR q<={sin,q[W-1:1]}, sout<=q[0]; ROTL q<={q[W-2:0],q[W-1]}, sout<=q[W-1]; ROTR q<={q[0],q[W-1:1]}, sout<=q[0]; ASR q<={q[W-1],q[W-1:1]}, sout<=q[0].
REQ-023 At edge t+N (last step): return to IDLE, busy<=0, done<=1 for exactly one cycle.
REQ-024 Latency: shift of N steps completes N+1 edges after start sample; busy high for exactly N cycles.
REQ-025 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 amount > WIDTH SHALL be honoured step-by-step (no clamping); shifts saturate to all-sin/all-sign, rotations wrap modulo WIDTH.
REQ-027 New command accepted on the cycle done=1 (back-to-back), since FSM is already IDLE.
REQ-028 Undefined or illegal inputs SHALL NOT affect q outside the rules above.

Reset
REQ-029 rst=1 SHALL immediately, without clk, force q=RST_VAL, qbar=~RST_VAL, sout=0, busy=0, done=0, FSM=IDLE, counter=0.
REQ-030 rst asserted mid-shift SHALL abort the operation; no done pulse issued for it.
REQ-031 First command accepted on the first posedge clk after rst deasserts.

Verification (WIDTH=8, AMT_W=4, RST_VAL=0)
REQ-032 rst pulse between edges -> q=0x00, qbar=0xFF, busy=0, done=0 before next edge.
REQ-033 load d=0xA5, then SHL amount=3 sin=0 -> busy high 3 cycles, q 0x4A,0x94,0x28, final sout=1, one done pulse.
REQ-034 load 0x80, ASR amount=2 -> q=0xE0, sout=0; load 0x81, ROTR amount=1 -> q=0xC0, sout=1, done after 2 edges.
REQ-035 SHR amount=4 sin=1 from 0x00, start pulsed with mode=001 mid-shift -> ignored, final q=0xF0.
REQ-036 SHL amount=0 -> q unchanged, busy never high, done pulse next cycle.
REQ-037 rst asserted after 2 of 5 SHL steps -> q=0x00 immediately, no done; fresh load 0x3C accepted after release.
